// File: rtl/led_sched_pkg.sv
// Shared types and strip codes for the backlight LED frame sequencer.
package led_sched_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned GRB_W  = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DIM,
        S_OFFER,
        S_STRIP_END,
        S_LATCH
    } state_t;

    typedef logic [GRB_W-1:0] grb_t;

    localparam logic [1:0] STRIP_UP    = 2'd0;
    localparam logic [1:0] STRIP_DOWN  = 2'd1;
    localparam logic [1:0] STRIP_LEFT  = 2'd2;
    localparam logic [1:0] STRIP_RIGHT = 2'd3;

endpackage

// File: rtl/led_dim_mult.sv
// Registered 8x8 channel scaler: dimmed = (ch * scale) >> 8. Used only when LED_DIM_EN is defined.
module led_dim_mult (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ch,
    input  logic [7:0] scale,
    output logic [7:0] dimmed
);

    logic [15:0] prod;

    assign prod = 16'(ch) * 16'(scale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dimmed <= 8'd0;
        end else begin
            dimmed <= prod[15:8];
        end
    end

endmodule

// File: rtl/led_strip_scheduler.sv
// Frame sequencer walking the colour table strip by strip (UP, DOWN, LEFT, RIGHT) into one serializer.
// Optional LED_DIM_EN adds a brightness port and a registered per-channel dimming stage.
module led_strip_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned UP_BASE    = 0,
    parameter int unsigned UP_LEN     = 32,
    parameter int unsigned DOWN_BASE  = 48,
    parameter int unsigned DOWN_LEN   = 32,
    parameter int unsigned LEFT_BASE  = 32,
    parameter int unsigned LEFT_LEN   = 16,
    parameter int unsigned RIGHT_BASE = 80,
    parameter int unsigned RIGHT_LEN  = 16,
    parameter int unsigned LATCH_CYC  = 6000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_req,
    output logic [6:0]  rd_addr,
    input  logic [23:0] rd_data,
    output logic        px_valid,
    output logic [23:0] px_data,
    input  logic        px_ready,
    input  logic        ser_idle,
    output logic [1:0]  strip_sel,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
`ifdef LED_DIM_EN
    ,
    input  logic [7:0]  brightness
`endif
);

    localparam int unsigned LATCH_W = $clog2(LATCH_CYC + 1);

    state_t             state;
    logic               pending;
    logic [1:0]         strip;
    logic [CNT_W-1:0]   pix_cnt;
    logic [LATCH_W-1:0] latch_cnt;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   len;

    assign strip_sel = strip;

    // Per-strip table window
    always_comb begin
        base = '0;
        len  = CNT_W'(1);
        case (strip)
            STRIP_UP:    begin base = ADDR_W'(UP_BASE);    len = CNT_W'(UP_LEN);    end
            STRIP_DOWN:  begin base = ADDR_W'(DOWN_BASE);  len = CNT_W'(DOWN_LEN);  end
            STRIP_LEFT:  begin base = ADDR_W'(LEFT_BASE);  len = CNT_W'(LEFT_LEN);  end
            STRIP_RIGHT: begin base = ADDR_W'(RIGHT_BASE); len = CNT_W'(RIGHT_LEN); end
            default:     begin base = '0;                  len = CNT_W'(1);         end
        endcase
    end

    len_nonzero: assert property (@(posedge clk) disable iff (!rst_n) len != '0)
        else $error("strip length of zero");

`ifdef LED_DIM_EN
    grb_t scaled;

    led_dim_mult u_dim_g (.clk(clk), .rst_n(rst_n), .ch(rd_data[23:16]), .scale(brightness), .dimmed(scaled[23:16]));
    led_dim_mult u_dim_r (.clk(clk), .rst_n(rst_n), .ch(rd_data[15:8]),  .scale(brightness), .dimmed(scaled[15:8]));
    led_dim_mult u_dim_b (.clk(clk), .rst_n(rst_n), .ch(rd_data[7:0]),   .scale(brightness), .dimmed(scaled[7:0]));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            strip      <= STRIP_UP;
            pix_cnt    <= '0;
            latch_cnt  <= '0;
            rd_addr    <= '0;
            px_valid   <= 1'b0;
            px_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;

            // One request may queue behind a running frame; a second one is dropped
            if (frame_req && state != S_IDLE) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (frame_req || pending) begin
                        state   <= S_FETCH;
                        busy    <= 1'b1;
                        strip   <= STRIP_UP;
                        pix_cnt <= '0;
                        // A fresh request arriving while a queued one launches stays queued
                        pending <= pending & frame_req;
                    end
                end
                S_FETCH: begin
                    rd_addr <= base + ADDR_W'(pix_cnt);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
`ifdef LED_DIM_EN
                    state    <= S_DIM;
`else
                    px_data  <= rd_data;
                    px_valid <= 1'b1;
                    state    <= S_OFFER;
`endif
                end
`ifdef LED_DIM_EN
                S_DIM: begin
                    px_data  <= scaled;
                    px_valid <= 1'b1;
                    state    <= S_OFFER;
                end
`endif
                S_OFFER: begin
                    if (px_ready) begin
                        px_valid <= 1'b0;
                        if (pix_cnt == len - CNT_W'(1)) begin
                            state <= S_STRIP_END;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                            state   <= S_FETCH;
                        end
                    end
                end
                S_STRIP_END: begin
                    if (ser_idle) begin
                        if (strip == STRIP_RIGHT) begin
                            latch_cnt <= LATCH_W'(LATCH_CYC - 1);
                            state     <= S_LATCH;
                        end else begin
                            strip   <= strip + 2'd1;
                            pix_cnt <= '0;
                            state   <= S_FETCH;
                        end
                    end
                end
                S_LATCH: begin
                    if (latch_cnt == '0) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt - LATCH_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    px_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
